// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/acknowledge and status bundle between the sequencer and its reset domains
interface reset_sequencer_if #(
    parameter int NDOMAINS = 4
);
    logic                swreq;
    logic [NDOMAINS-1:0] domack;
    logic [NDOMAINS-1:0] resets;
    logic                busy;
    logic                ready;
    logic                timeout;

    modport master (
        input  swreq, domack,
        output resets, busy, ready, timeout
    );

    modport slave (
        output swreq, domack,
        input  resets, busy, ready, timeout
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases NDOMAINS domain resets in order, each gated by the previous domain's ack
// Optional ack-wait timeout with ERROR state when RSTSEQ_TIMEOUT_EN is defined.
module reset_sequencer #(
    parameter int NDOMAINS = 4,
    parameter int HOLD     = 16,
    parameter int GAP      = 4,
    parameter int TIMEOUT  = 256
) (
    input  logic              clock,
    input  logic              sreset,
    reset_sequencer_if.master rs
);
    localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
    localparam int MAXC  = (MAXHG > TIMEOUT) ? MAXHG : TIMEOUT;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int SW    = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_WAITACK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t              state, state_d;
    logic [CW-1:0]       cnt, cnt_d, cnt_inc;
    logic [SW-1:0]       stage, stage_d;
    logic [NDOMAINS-1:0] resets_d;
    logic                busy_d, ready_d, timeout_d;

    // Saturating increment: the counter parks at its terminal value instead of wrapping.
    assign cnt_inc = (cnt == CW'(MAXC)) ? cnt : cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (sreset) begin
            state      <= ST_ASSERT;
            cnt        <= '0;
            stage      <= '0;
            rs.resets  <= '1;
            rs.busy    <= 1'b1;
            rs.ready   <= 1'b0;
            rs.timeout <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            stage      <= stage_d;
            rs.resets  <= resets_d;
            rs.busy    <= busy_d;
            rs.ready   <= ready_d;
            rs.timeout <= timeout_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        stage_d = stage;
        if (rs.swreq) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            stage_d = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == CW'(HOLD - 1)) begin
                        state_d = ST_RELEASE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == CW'(GAP - 1)) begin
                        state_d = ST_WAITACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAITACK: begin
                    // The ack wins over an expiring timeout on the same edge.
                    if (rs.domack[stage]) begin
                        cnt_d = '0;
                        if (stage == SW'(NDOMAINS - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RELEASE;
                            stage_d = stage + 1'b1;
                        end
                    end
`ifdef RSTSEQ_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered values line up with the transition edge.
    always_comb begin
        resets_d  = '1;
        busy_d    = 1'b0;
        ready_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_d)
            ST_ASSERT: busy_d = 1'b1;
            ST_RELEASE, ST_WAITACK: begin
                busy_d = 1'b1;
                for (int i = 0; i < NDOMAINS; i++) begin
                    resets_d[i] = (i > int'(stage_d));
                end
            end
            ST_DONE: begin
                resets_d = '0;
                ready_d  = 1'b1;
            end
            ST_ERROR: begin
`ifdef RSTSEQ_TIMEOUT_EN
                timeout_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end
endmodule
